// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared opcode and state types for the parametrised MU0 core
package mu0_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STO = 4'd1,
        OP_ADD = 4'd2,
        OP_SUB = 4'd3,
        OP_JMP = 4'd4,
        OP_JGE = 4'd5,
        OP_JNE = 4'd6,
        OP_STP = 4'd7,
        OP_OUT = 4'd8
    } opcode_t;

    // HALTED is the all-zero encoding so an unreset core comes up idle.
    typedef enum logic [1:0] {
        HALTED = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2
    } state_t;

endpackage

// File: rtl/mu0_alu.sv
// rtl/mu0_alu.sv - combinational accumulator datapath and opcode decode
module mu0_alu
    import mu0_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  opcode_t               opcode,
    output logic [DATA_WIDTH-1:0] acc_next,
    output logic                  is_mem_op,
    output logic                  is_illegal
);

    always_comb begin
        acc_next   = acc;
        is_mem_op  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_LDA: begin
                acc_next  = readdata;
                is_mem_op = 1'b1;
            end
            OP_ADD: begin
                acc_next  = acc + readdata;
                is_mem_op = 1'b1;
            end
            OP_SUB: begin
                acc_next  = acc - readdata;
                is_mem_op = 1'b1;
            end
            OP_STO: is_mem_op = 1'b1;
            OP_JMP, OP_JGE, OP_JNE, OP_STP, OP_OUT: ;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mu0_cpu_param.sv
// rtl/mu0_cpu_param.sv - MU0 accumulator CPU with waitrequest bus handshake
module mu0_cpu_param
    import mu0_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    localparam int                   DATA_WIDTH   = ADDR_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  running,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    input  logic                  waitrequest,
    output logic [DATA_WIDTH-1:0] writedata,
    input  logic [DATA_WIDTH-1:0] readdata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0]   ir;
    logic [DATA_WIDTH-1:0]   acc;
    logic [DATA_WIDTH-1:0]   acc_next;
    logic                    is_mem_op;
    logic                    is_illegal;
    opcode_t                 opcode;
    logic [ADDR_WIDTH-1:0]   operand;

    assign opcode    = opcode_t'(ir[DATA_WIDTH-1 -: 4]);
    assign operand   = ir[ADDR_WIDTH-1:0];
    assign writedata = acc;

    mu0_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .acc        (acc),
        .readdata   (readdata),
        .opcode     (opcode),
        .acc_next   (acc_next),
        .is_mem_op  (is_mem_op),
        .is_illegal (is_illegal)
    );

    // Bus strobes depend only on state and IR, so they hold steady across stalls.
    always_comb begin
        address = pc;
        read    = 1'b0;
        write   = 1'b0;
        if (state == FETCH) begin
            read = 1'b1;
        end else if (state == EXEC && is_mem_op) begin
            address = operand;
            if (opcode == OP_STO) begin
                write = 1'b1;
            end else begin
                read = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_VECTOR;
            acc       <= '0;
            running   <= 1'b1;
            error     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: begin
                    if (!waitrequest) begin
                        ir    <= readdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_illegal) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        error   <= 1'b1;
                    end else if (is_mem_op) begin
                        if (!waitrequest) begin
                            acc   <= acc_next;
                            pc    <= pc + PC_ONE;
                            state <= FETCH;
                        end
                    end else begin
                        state <= FETCH;
                        pc    <= pc + PC_ONE;
                        case (opcode)
                            OP_JMP: pc <= operand;
                            OP_JGE: if ($signed(acc) >= 0) pc <= operand;
                            OP_JNE: if (acc != '0) pc <= operand;
                            OP_OUT: begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                            end
                            OP_STP: begin
                                pc      <= pc;
                                state   <= HALTED;
                                running <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_cpu_param.sv
// tb/tb_mu0_cpu_param.sv - scoreboard bench for mu0_cpu_param
module tb_mu0_cpu_param;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          running, error, read, write, out_valid;
    logic          waitrequest = 1'b0;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata, readdata, out_data;

    logic [DW-1:0]    mem [0:(1<<AW)-1];
    logic [DW-1:0]    out_q[$];
    logic [AW+DW-1:0] wr_q[$];

    int total = 0;
    int bad = 0;
    int max_wait = 0;
    int stall_left = 0;
    int out_pulses = 0;
    bit stall_writes = 1'b0;
    bit prev_stall = 1'b0;
    logic [AW-1:0] s_addr;
    logic s_rd, s_wr;

    always #5 clk = ~clk;

    mu0_cpu_param #(.ADDR_WIDTH(AW), .RESET_VECTOR(12'h000)) dut (
        .clk         (clk),
        .rst         (rst),
        .running     (running),
        .error       (error),
        .address     (address),
        .read        (read),
        .write       (write),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .readdata    (readdata),
        .out_valid   (out_valid),
        .out_data    (out_data)
    );

    assign readdata = mem[address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (write && !waitrequest && !rst) mem[address] = writedata;
    end

    // Memory stall generator plus scoreboard monitor, all on the falling edge.
    always @(negedge clk) begin
        logic [AW+DW-1:0] wexp;
        logic [DW-1:0]    oexp;
        if (prev_stall) begin
            check("stall_addr", 32'(address), 32'(s_addr));
            check("stall_rw", {30'd0, read, write}, {30'd0, s_rd, s_wr});
        end
        if (write && stall_writes) begin
            waitrequest = 1'b1;
        end else if ((read || write) && !rst) begin
            if (stall_left > 0) begin
                waitrequest = 1'b1;
                stall_left--;
            end else begin
                waitrequest = 1'b0;
                stall_left = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
            end
        end else begin
            waitrequest = 1'b0;
        end
        prev_stall = waitrequest && !rst && (read || write);
        s_addr = address;
        s_rd = read;
        s_wr = write;
        if (read && write) check("rw_exclusive", 32'(read & write), 32'd0);
        if (write && !waitrequest && !rst) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'({address, writedata}), 32'hFFFF_FFFF);
            end else begin
                wexp = wr_q.pop_front();
                check("write", 32'({address, writedata}), 32'(wexp));
            end
        end
        if (out_valid) begin
            out_pulses++;
            if (out_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                oexp = out_q.pop_front();
                check("out_data", 32'(out_data), 32'(oexp));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input int limit, output int cyc);
        cyc = 0;
        while (running && cyc < limit) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        check("run_timeout", 32'(running), 32'd0);
    endtask

    task automatic load_basic();
        mem[12'h000] = 16'h0010;
        mem[12'h001] = 16'h2011;
        mem[12'h002] = 16'h1012;
        mem[12'h003] = 16'h8000;
        mem[12'h004] = 16'h7000;
        mem[12'h010] = 16'd5;
        mem[12'h011] = 16'd3;
        mem[12'h012] = 16'h0000;
    endtask

    initial begin
        int cyc;
        int p0;
        int busy;

        // Reset state
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_running", 32'(running), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fetch", {29'd0, read, write, 1'b0}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("rst_address", 32'(address), 32'h000);
        rst = 1'b1;

        // Zero-wait basic program
        load_basic();
        out_q.push_back(16'd8);
        wr_q.push_back({12'h012, 16'd8});
        p0 = out_pulses;
        do_reset();
        run(200, cyc);
        check("basic_cycles", 32'(cyc), 32'd10);
        check("basic_mem", 32'(mem[12'h012]), 32'd8);
        check("basic_out_data", 32'(out_data), 32'd8);
        check("basic_pulses", 32'(out_pulses - p0), 32'd1);
        check("basic_error", 32'(error), 32'd0);

        // Same program under random stalls
        load_basic();
        max_wait = 5;
        stall_left = 0;
        out_q.push_back(16'd8);
        wr_q.push_back({12'h012, 16'd8});
        p0 = out_pulses;
        do_reset();
        run(2000, cyc);
        max_wait = 0;
        check("stall_mem", 32'(mem[12'h012]), 32'd8);
        check("stall_out_data", 32'(out_data), 32'd8);
        check("stall_pulses", 32'(out_pulses - p0), 32'd1);

        // Countdown loop, JGE taken at 0 and not taken at 0x8000
        mem[12'h000] = 16'h0020;
        mem[12'h001] = 16'h3021;
        mem[12'h002] = 16'h8000;
        mem[12'h003] = 16'h6001;
        mem[12'h004] = 16'h5006;
        mem[12'h005] = 16'h7000;
        mem[12'h006] = 16'h0022;
        mem[12'h007] = 16'h5009;
        mem[12'h008] = 16'h8000;
        mem[12'h009] = 16'h7000;
        mem[12'h020] = 16'd3;
        mem[12'h021] = 16'd1;
        mem[12'h022] = 16'h8000;
        out_q.push_back(16'd2);
        out_q.push_back(16'd1);
        out_q.push_back(16'd0);
        out_q.push_back(16'h8000);
        p0 = out_pulses;
        do_reset();
        run(500, cyc);
        check("loop_pulses", 32'(out_pulses - p0), 32'd4);
        check("loop_error", 32'(error), 32'd0);

        // Overflow and PC wrap from 0xFFF
        mem[12'h000] = 16'h6003;
        mem[12'h001] = 16'h4FFF;
        mem[12'hFFF] = 16'h0030;
        mem[12'h003] = 16'h2031;
        mem[12'h004] = 16'h1032;
        mem[12'h005] = 16'h8000;
        mem[12'h006] = 16'h7000;
        mem[12'h030] = 16'hFFFF;
        mem[12'h031] = 16'h0001;
        mem[12'h032] = 16'h5555;
        out_q.push_back(16'h0000);
        wr_q.push_back({12'h032, 16'h0000});
        do_reset();
        run(500, cyc);
        check("wrap_mem", 32'(mem[12'h032]), 32'd0);
        check("wrap_out_data", 32'(out_data), 32'd0);

        // Illegal opcode trap
        mem[12'h000] = 16'h0010;
        mem[12'h001] = 16'hA000;
        do_reset();
        run(200, cyc);
        check("trap_error", 32'(error), 32'd1);
        check("trap_running", 32'(running), 32'd0);
        busy = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (read || write) busy++;
        end
        check("trap_bus_idle", 32'(busy), 32'd0);

        // Reset during a stalled STO
        mem[12'h000] = 16'h0010;
        mem[12'h001] = 16'h1040;
        mem[12'h002] = 16'h7000;
        mem[12'h010] = 16'd5;
        mem[12'h040] = 16'h1234;
        stall_writes = 1'b1;
        do_reset();
        cyc = 0;
        while (!write && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("sto_reached", 32'(write), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("sto_held", {30'd0, read, write}, {30'd0, 1'b0, 1'b1});
        check("sto_address", 32'(address), 32'h040);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstsw_write", 32'(write), 32'd0);
        check("rstsw_read", 32'(read), 32'd1);
        check("rstsw_pc", 32'(address), 32'h000);
        check("rstsw_mem", 32'(mem[12'h040]), 32'h1234);
        wr_q.push_back({12'h040, 16'd5});
        stall_writes = 1'b0;
        rst = 1'b0;
        run(200, cyc);
        check("rerun_mem", 32'(mem[12'h040]), 32'd5);

        check("out_q_drained", 32'(out_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
